// File: rtl/p1v_reset_io.sv
// p1v_reset_io: reset merging/stretching, sticky reset cause and pad conditioning for the p1v core
module p1v_reset_io #(
    parameter int                     NUM_PINS        = 32,
    parameter int                     NUM_RST_SRC     = 2,
    parameter int                     SYNC_STAGES     = 2,
    parameter logic [NUM_RST_SRC-1:0] DEBOUNCE_MASK   = 2'b01,
    parameter int                     DEBOUNCE_CYCLES = 1_600_000,
    parameter int                     RESET_STRETCH   = 16
) (
    input  logic                   clock_160,
    input  logic                   inp_resn,
    input  logic [NUM_RST_SRC-1:0] rst_src_n,
    input  logic [NUM_PINS-1:0]    pin_in_raw,
    output logic [NUM_PINS-1:0]    pin_in,
    input  logic [NUM_PINS-1:0]    pin_out,
    input  logic [NUM_PINS-1:0]    pin_dir,
    output logic [NUM_PINS-1:0]    pad_out,
    output logic [NUM_PINS-1:0]    pad_oe,
    output logic                   core_resn,
    output logic [NUM_RST_SRC:0]   reset_cause
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = $clog2(RESET_STRETCH + 1);

    typedef enum logic [1:0] {RUN, HOLD, STRETCH} state_t;

    logic [1:0]                             rst_sync;
    logic                                   rst_n;
    logic [NUM_RST_SRC-1:0]                 filt;
    logic [NUM_RST_SRC-1:0]                 act;
    logic                                   any_act;
    logic [NUM_RST_SRC:0]                   act_cause;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0]   pin_sync;
    state_t                                 state;
    logic [SW-1:0]                          cnt;

    assign rst_n = rst_sync[1];

    // master reset: asserts immediately, releases on the second clock edge
    always_ff @(posedge clock_160 or negedge inp_resn)
        if (!inp_resn)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};

    for (genvar k = 0; k < NUM_RST_SRC; k++) begin : g_src
        logic [SYNC_STAGES-1:0] sync;

        // source synchroniser, idles inactive (high)
        always_ff @(posedge clock_160 or negedge rst_n)
            if (!rst_n)
                sync <= '1;
            else
                sync <= {sync[SYNC_STAGES-2:0], rst_src_n[k]};

        if (DEBOUNCE_MASK[k]) begin : g_deb
            logic [DW-1:0] dcnt;
            logic          f;

            // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
            always_ff @(posedge clock_160 or negedge rst_n)
                if (!rst_n) begin
                    dcnt <= '0;
                    f    <= 1'b1;
                end else if (sync[SYNC_STAGES-1] == f) begin
                    dcnt <= '0;
                end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    dcnt <= '0;
                    f    <= sync[SYNC_STAGES-1];
                end else begin
                    dcnt <= dcnt + 1'b1;
                end

            assign filt[k] = f;
        end else begin : g_raw
            assign filt[k] = sync[SYNC_STAGES-1];
        end
    end

    assign act       = ~filt;
    assign any_act   = |act;
    assign act_cause = {1'b0, act};

    // reset sequencer: RUN releases the core, HOLD tracks active sources, STRETCH counts down the tail
    always_ff @(posedge clock_160 or negedge rst_n)
        if (!rst_n) begin
            state       <= STRETCH;
            cnt         <= SW'(RESET_STRETCH);
            core_resn   <= 1'b0;
            reset_cause <= {1'b1, {NUM_RST_SRC{1'b0}}};
        end else begin
            case (state)
                RUN:
                    if (any_act) begin
                        state       <= HOLD;
                        core_resn   <= 1'b0;
                        reset_cause <= act_cause;
                    end
                HOLD: begin
                    reset_cause <= reset_cause | act_cause;
                    if (!any_act) begin
                        state <= STRETCH;
                        cnt   <= SW'(RESET_STRETCH);
                    end
                end
                STRETCH:
                    if (any_act) begin
                        state       <= HOLD;
                        reset_cause <= reset_cause | act_cause;
                    end else if (cnt == SW'(1)) begin
                        state     <= RUN;
                        core_resn <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                default: state <= STRETCH;
            endcase
        end

    // pad input synchroniser
    always_ff @(posedge clock_160 or negedge rst_n)
        if (!rst_n)
            pin_sync <= '0;
        else
            pin_sync <= {pin_sync[SYNC_STAGES-2:0], pin_in_raw};

    assign pin_in  = pin_sync[SYNC_STAGES-1];
    assign pad_out = pin_out;
    assign pad_oe  = pin_dir & {NUM_PINS{core_resn}};
endmodule

// File: tb/tb_p1v_reset_io.sv
// tb_p1v_reset_io: randomized self-checking bench for p1v_reset_io against a history-based reference model
module tb_p1v_reset_io;
    localparam int         NP = 32;
    localparam int         NS = 2;
    localparam int         SS = 2;
    localparam int         DC = 8;
    localparam int         RS = 4;
    localparam logic [1:0] DM = 2'b01;

    logic          clock_160 = 1'b0;
    logic          inp_resn;
    logic [NS-1:0] rst_src_n;
    logic [NP-1:0] pin_in_raw, pin_out, pin_dir;
    logic [NP-1:0] pin_in, pad_out, pad_oe;
    logic          core_resn;
    logic [NS:0]   reset_cause;

    int n_checks = 0;
    int n_fail   = 0;

    int            held;
    int            quiet;
    int            m_run[NS];
    logic [NS-1:0] m_filt;
    logic [NS:0]   m_cause;
    logic [NS-1:0] src_q[$];
    logic [NP-1:0] pin_q[$];
    logic          rand_pins;
    int            low_left[NS];

    always #5 clock_160 = ~clock_160;

    p1v_reset_io #(
        .NUM_PINS(NP), .NUM_RST_SRC(NS), .SYNC_STAGES(SS),
        .DEBOUNCE_MASK(DM), .DEBOUNCE_CYCLES(DC), .RESET_STRETCH(RS)
    ) dut (
        .clock_160(clock_160), .inp_resn(inp_resn), .rst_src_n(rst_src_n),
        .pin_in_raw(pin_in_raw), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
        .pad_out(pad_out), .pad_oe(pad_oe), .core_resn(core_resn), .reset_cause(reset_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // quiet counts consecutive edges with no filtered source active; core runs once it exceeds RS
    function automatic void model_reset();
        held    = 2;
        quiet   = 1;
        m_filt  = '1;
        m_cause = {1'b1, {NS{1'b0}}};
        for (int k = 0; k < NS; k++) m_run[k] = 0;
        src_q = {};
        pin_q = {};
        for (int i = 0; i < SS; i++) begin
            src_q.push_back({NS{1'b1}});
            pin_q.push_back({NP{1'b0}});
        end
    endfunction

    function automatic void model_edge();
        logic [NS-1:0] act, view;
        if (!inp_resn) begin
            model_reset();
            return;
        end
        if (held > 0) begin
            held--;
            return;
        end
        act = ~m_filt;
        if (|act) begin
            m_cause = (quiet > RS) ? {1'b0, act} : (m_cause | {1'b0, act});
            quiet   = 0;
        end else if (quiet < 1000) begin
            quiet++;
        end
        view = src_q[0];
        for (int k = 0; k < NS; k++)
            if (DM[k]) begin
                if (view[k] != m_filt[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        m_filt[k] = view[k];
                        m_run[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        src_q.push_back(rst_src_n);
        void'(src_q.pop_front());
        pin_q.push_back(pin_in_raw);
        void'(pin_q.pop_front());
        for (int k = 0; k < NS; k++)
            if (!DM[k]) m_filt[k] = src_q[0][k];
    endfunction

    task automatic check_all();
        logic m_core;
        m_core = (quiet > RS);
        check("core_resn", 32'(core_resn), 32'(m_core));
        check("reset_cause", 32'(reset_cause), 32'(m_cause));
        check("pin_in", pin_in, pin_q[0]);
        check("pad_oe", pad_oe, pin_dir & {NP{m_core}});
        check("pad_out", pad_out, pin_out);
    endtask

    task automatic tick();
        if (rand_pins) begin
            pin_in_raw = $urandom;
            pin_out    = $urandom;
            pin_dir    = $urandom;
        end
        @(posedge clock_160);
        model_edge();
        #1;
        check_all();
        @(negedge clock_160);
    endtask

    task automatic master_pulse(input int len);
        inp_resn = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (len) tick();
        inp_resn = 1'b1;
    endtask

    initial begin
        inp_resn   = 1'b0;
        rst_src_n  = '1;
        pin_in_raw = '0;
        pin_out    = '0;
        pin_dir    = '1;
        rand_pins  = 1'b0;
        for (int k = 0; k < NS; k++) low_left[k] = 0;
        model_reset();

        // master reset then release
        repeat (5) tick();
        check("t1_cause", 32'(reset_cause), 32'h4);
        check("t1_oe_rst", pad_oe, 32'h0);
        inp_resn = 1'b1;
        repeat (5) tick();
        check("t1_edge5", 32'(core_resn), 32'h0);
        tick();
        check("t1_edge6", 32'(core_resn), 32'h1);
        repeat (3) tick();

        // pads in RUN and pin input latency
        pin_dir = 32'hFFFF_FFFF;
        pin_out = 32'hA5A5_5A5A;
        #1;
        check("t5_oe_run", pad_oe, 32'hFFFF_FFFF);
        check("t5_pad_out", pad_out, 32'hA5A5_5A5A);
        pin_in_raw = 32'h1234_5678;
        tick();
        check("t5_pin_lat1", pin_in, 32'h0);
        tick();
        check("t5_pin_lat2", pin_in, 32'h1234_5678);

        // one-cycle pulse on the non-debounced source
        rst_src_n[1] = 1'b0;
        tick();
        rst_src_n[1] = 1'b1;
        tick();
        check("t2_edge2", 32'(core_resn), 32'h1);
        tick();
        check("t2_edge3", 32'(core_resn), 32'h0);
        check("t2_cause", 32'(reset_cause), 32'h2);
        check("t2_oe_rst", pad_oe, 32'h0);
        repeat (4) tick();
        check("t2_edge7", 32'(core_resn), 32'h0);
        tick();
        check("t2_edge8", 32'(core_resn), 32'h1);
        repeat (5) tick();

        // debounce rejects 7 cycles, accepts 8
        rst_src_n[0] = 1'b0;
        repeat (7) tick();
        rst_src_n[0] = 1'b1;
        repeat (25) tick();
        check("t3_reject", 32'(core_resn), 32'h1);
        rst_src_n[0] = 1'b0;
        repeat (8) tick();
        rst_src_n[0] = 1'b1;
        repeat (2) tick();
        check("t3_edge10", 32'(core_resn), 32'h1);
        tick();
        check("t3_edge11", 32'(core_resn), 32'h0);
        check("t3_cause", 32'(reset_cause), 32'h1);
        repeat (25) tick();

        // overlapping sources accumulate; a pulse in STRETCH restarts the tail
        rst_src_n[0] = 1'b0;
        repeat (14) tick();
        rst_src_n[1] = 1'b0;
        tick();
        rst_src_n[1] = 1'b1;
        repeat (3) tick();
        check("t4_cause", 32'(reset_cause), 32'h3);
        rst_src_n[0] = 1'b1;
        repeat (11) tick();
        rst_src_n[1] = 1'b0;
        tick();
        rst_src_n[1] = 1'b1;
        repeat (25) tick();

        // both filtered sources assert on the same edge
        rst_src_n[0] = 1'b0;
        repeat (8) tick();
        rst_src_n[1] = 1'b0;
        repeat (6) tick();
        rst_src_n = '1;
        repeat (30) tick();

        // master reset aborts STRETCH
        rst_src_n[1] = 1'b0;
        tick();
        rst_src_n[1] = 1'b1;
        repeat (5) tick();
        inp_resn = 1'b0;
        #1;
        check("t6_core", 32'(core_resn), 32'h0);
        check("t6_cause", 32'(reset_cause), 32'h4);
        check("t6_pin_in", pin_in, 32'h0);
        master_pulse(2);
        repeat (15) tick();

        // random traffic with occasional master resets
        rand_pins = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NS; k++) begin
                if (low_left[k] == 0 && $urandom_range(0, 99) < 3) low_left[k] = $urandom_range(1, 14);
                rst_src_n[k] = (low_left[k] == 0);
                if (low_left[k] > 0) low_left[k]--;
            end
            if ($urandom_range(0, 999) < 4) master_pulse($urandom_range(1, 4));
            tick();
        end
        rst_src_n = '1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
